mcycle_unit: RTL and testbench

MCYCLE_UNIT -- requirements
Module: mcycle_unit

---
 rtl/mcycle_pkg.sv | 29 ++
 rtl/mcycle_sign_fix.sv | 49 ++++
 rtl/mcycle_unit.sv | 146 ++++++++++++++
 tb/tb_mcycle_unit.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/mcycle_pkg.sv
// Shared definitions for the multi-cycle multiply/divide unit.
package mcycle_pkg;

  localparam int unsigned WIDTH_DEF = 32;
  localparam int unsigned N_ITER    = 32;
  localparam int unsigned CNT_W     = 5;
  localparam int unsigned ADD_W     = WIDTH_DEF + 1;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(N_ITER - 1);

  typedef enum logic [1:0] {
    MUL_S = 2'b00,
    MUL_U = 2'b01,
    DIV_S = 2'b10,
    DIV_U = 2'b11
  } op_e;

  typedef logic [0:0] state_t;
  localparam state_t S_IDLE    = 1'b0;
  localparam state_t S_COMPUTE = 1'b1;

  // Single shared adder/subtractor used by both shift-add and restoring division.
  function automatic logic [ADD_W-1:0] addsub(input logic [ADD_W-1:0] a,
                                              input logic [ADD_W-1:0] b,
                                              input logic             sub);
    return a + (sub ? ~b : b) + {{(ADD_W-1){1'b0}}, sub};
  endfunction

endpackage

// File: rtl/mcycle_sign_fix.sv
// Operand magnitude extraction at start, and sign restoration of the raw result.
module mcycle_sign_fix
  import mcycle_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  op_e                  op_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  output logic [WIDTH-1:0]     a_mag_o,
  output logic [WIDTH-1:0]     b_mag_o,
  output logic                 a_neg_o,
  output logic                 b_neg_o,
  output logic                 b_zero_o,
  input  op_e                  fin_op_i,
  input  logic                 fin_a_neg_i,
  input  logic                 fin_b_neg_i,
  input  logic                 fin_b_zero_i,
  input  logic [2*WIDTH-1:0]   raw_i,
  output logic [2*WIDTH-1:0]   res_o
);

  logic             signed_op;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;

  assign signed_op = (op_i == MUL_S) || (op_i == DIV_S);
  assign a_neg_o   = signed_op & a_i[WIDTH-1];
  assign b_neg_o   = signed_op & b_i[WIDTH-1];
  assign a_mag_o   = a_neg_o ? -a_i : a_i;
  assign b_mag_o   = b_neg_o ? -b_i : b_i;
  assign b_zero_o  = (b_i == '0);

  always_comb begin
    res_o = raw_i;
    quo   = raw_i[WIDTH-1:0];
    rem   = raw_i[2*WIDTH-1:WIDTH];
    if ((fin_op_i == MUL_S) || (fin_op_i == MUL_U)) begin
      if (fin_a_neg_i ^ fin_b_neg_i) res_o = -raw_i;
    end else begin
      // Zero divisor: all-ones quotient; remainder already carries the dividend magnitude.
      if (fin_b_zero_i)                    quo = '1;
      else if (fin_a_neg_i ^ fin_b_neg_i)  quo = -quo;
      if (fin_a_neg_i)                     rem = -rem;
      res_o = {rem, quo};
    end
  end

endmodule

// File: rtl/mcycle_unit.sv
// 32-iteration multi-cycle multiplier/divider sharing one shift register and one adder.
module mcycle_unit
  import mcycle_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             Start,
  input  logic [1:0]       MCycleOp,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  output logic [WIDTH-1:0] Result1,
  output logic [WIDTH-1:0] Result2,
  output logic             Busy
);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  op_e                  op_q, op_d;
  logic [2*WIDTH-1:0]   sreg_q, sreg_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic                 a_neg_q, a_neg_d;
  logic                 b_neg_q, b_neg_d;
  logic                 b_zero_q, b_zero_d;
  logic [WIDTH-1:0]     res1_q, res1_d;
  logic [WIDTH-1:0]     res2_q, res2_d;

  logic [WIDTH-1:0]     a_mag, b_mag;
  logic                 a_neg, b_neg, b_zero;
  logic [2*WIDTH-1:0]   res_fix;

  logic                 is_div;
  logic [WIDTH-1:0]     hi, lo;
  logic [WIDTH:0]       add_a, add_b, sum, mul_acc;
  logic [2*WIDTH-1:0]   sreg_step;

  mcycle_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
    .op_i        (op_e'(MCycleOp)),
    .a_i         (Operand1),
    .b_i         (Operand2),
    .a_mag_o     (a_mag),
    .b_mag_o     (b_mag),
    .a_neg_o     (a_neg),
    .b_neg_o     (b_neg),
    .b_zero_o    (b_zero),
    .fin_op_i    (op_q),
    .fin_a_neg_i (a_neg_q),
    .fin_b_neg_i (b_neg_q),
    .fin_b_zero_i(b_zero_q),
    .raw_i       (sreg_step),
    .res_o       (res_fix)
  );

  assign Busy    = ((state_q == S_IDLE) && Start) || (state_q == S_COMPUTE);
  assign Result1 = res1_q;
  assign Result2 = res2_q;

  // Multiply: {hi,lo} = {accumulator, multiplier}, shifting right.
  // Divide:   {hi,lo} = {partial remainder, dividend/quotient}, shifting left.
  always_comb begin
    is_div    = (op_q == DIV_S) || (op_q == DIV_U);
    hi        = sreg_q[2*WIDTH-1:WIDTH];
    lo        = sreg_q[WIDTH-1:0];
    add_b     = {1'b0, mcand_q};
    add_a     = is_div ? {hi, lo[WIDTH-1]} : {1'b0, hi};
    sum       = addsub(add_a, add_b, is_div);
    mul_acc   = lo[0] ? sum : add_a;
    if (is_div) begin
      if (!sum[WIDTH]) sreg_step = {sum[WIDTH-1:0], lo[WIDTH-2:0], 1'b1};
      else             sreg_step = {add_a[WIDTH-1:0], lo[WIDTH-2:0], 1'b0};
    end else begin
      sreg_step = {mul_acc, lo[WIDTH-1:1]};
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    sreg_d   = sreg_q;
    mcand_d  = mcand_q;
    a_neg_d  = a_neg_q;
    b_neg_d  = b_neg_q;
    b_zero_d = b_zero_q;
    res1_d   = res1_q;
    res2_d   = res2_q;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          state_d  = S_COMPUTE;
          cnt_d    = '0;
          op_d     = op_e'(MCycleOp);
          a_neg_d  = a_neg;
          b_neg_d  = b_neg;
          b_zero_d = b_zero;
          if (MCycleOp[1]) begin
            sreg_d  = {{WIDTH{1'b0}}, a_mag};
            mcand_d = b_mag;
          end else begin
            sreg_d  = {{WIDTH{1'b0}}, b_mag};
            mcand_d = a_mag;
          end
        end
      end
      S_COMPUTE: begin
        sreg_d = sreg_step;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          res1_d  = res_fix[WIDTH-1:0];
          res2_d  = res_fix[2*WIDTH-1:WIDTH];
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= MUL_S;
      sreg_q   <= '0;
      mcand_q  <= '0;
      a_neg_q  <= 1'b0;
      b_neg_q  <= 1'b0;
      b_zero_q <= 1'b0;
      res1_q   <= '0;
      res2_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      sreg_q   <= sreg_d;
      mcand_q  <= mcand_d;
      a_neg_q  <= a_neg_d;
      b_neg_q  <= b_neg_d;
      b_zero_q <= b_zero_d;
      res1_q   <= res1_d;
      res2_q   <= res2_d;
    end
  end

endmodule

// File: tb/tb_mcycle_unit.sv
// Scoreboard bench for mcycle_unit: directed vectors, monitor checks on Busy completion.
module tb_mcycle_unit;
  import mcycle_pkg::*;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        Start = 1'b0;
  logic [1:0]  MCycleOp = 2'b00;
  logic [31:0] Operand1 = '0;
  logic [31:0] Operand2 = '0;
  logic [31:0] Result1, Result2;
  logic        Busy;

  mcycle_unit #(.WIDTH(32)) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .Start   (Start),
    .MCycleOp(MCycleOp),
    .Operand1(Operand1),
    .Operand2(Operand2),
    .Result1 (Result1),
    .Result2 (Result2),
    .Busy    (Busy)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       name;
    logic [31:0] r1;
    logic [31:0] r2;
  } exp_t;

  exp_t        sb[$];
  exp_t        cur;
  int          errors = 0;
  int          checks = 0;
  int          bcnt = 0;
  logic        prev_busy = 1'b0;
  logic [31:0] last_r1 = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: a Busy falling edge (outside reset) marks a completed operation.
  initial forever begin
    @(negedge CLK);
    if (!RESET) begin
      bcnt      = 0;
      prev_busy = 1'b0;
    end else begin
      if (Busy) bcnt++;
      else if (prev_busy) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got %h/%h expected no completion", Result1, Result2);
        end else begin
          cur = sb.pop_front();
          chk({cur.name, "_r1"}, Result1, cur.r1);
          chk({cur.name, "_r2"}, Result2, cur.r2);
          chk({cur.name, "_busy_cycles"}, 32'(bcnt), 32'd33);
        end
        bcnt = 0;
      end
      prev_busy = Busy;
    end
  end

  task automatic wait_done(input string name);
    int t = 0;
    while (Busy === 1'b1 && t < 60) begin
      @(posedge CLK);
      #1;
      t++;
    end
    chk({name, "_done_in_time"}, {31'b0, Busy}, 32'd0);
  endtask

  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] e1, input logic [31:0] e2);
    @(posedge CLK);
    #1;
    MCycleOp = op;
    Operand1 = a;
    Operand2 = b;
    Start    = 1'b1;
    sb.push_back('{name, e1, e2});
    #1 chk({name, "_busy_rise"}, {31'b0, Busy}, 32'd1);
    @(posedge CLK);
    #1;
    Start    = 1'b0;
    MCycleOp = ~op;
    Operand1 = $urandom;
    Operand2 = $urandom;
    chk({name, "_hold_mid"}, Result1, last_r1);
    wait_done(name);
    last_r1 = e1;
    @(negedge CLK);
  endtask

  initial begin
    int hi_seen;
    #1;
    chk("reset_busy", {31'b0, Busy}, 32'd0);
    chk("reset_r1", Result1, 32'd0);
    chk("reset_r2", Result2, 32'd0);
    repeat (2) @(negedge CLK);
    RESET = 1'b1;

    run_op("mulu_7x6",    MUL_U, 32'd7,        32'd6,        32'd42,       32'd0);
    run_op("muls_m3x5",   MUL_S, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1, 32'hFFFFFFFF);
    run_op("mulu_max",    MUL_U, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE);
    run_op("muls_min_m1", MUL_S, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000);
    run_op("muls_m1xm1",  MUL_S, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'h00000000);
    run_op("divu_100_7",  DIV_U, 32'd100,      32'd7,        32'd14,       32'd2);
    run_op("divs_m7_2",   DIV_S, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF);
    run_op("divs_7_m2",   DIV_S, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1);
    run_op("divs_ovf",    DIV_S, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000);
    run_op("divu_5_0",    DIV_U, 32'd5,        32'd0,        32'hFFFFFFFF, 32'd5);
    run_op("divs_m5_0",   DIV_S, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFFB);

    // Inputs and a Start pulse mid-computation must be ignored.
    @(posedge CLK);
    #1;
    MCycleOp = MUL_U;
    Operand1 = 32'd3;
    Operand2 = 32'd3;
    Start    = 1'b1;
    sb.push_back('{"mul_3x3_ign", 32'd9, 32'd0});
    @(posedge CLK);
    #1 Start = 1'b0;
    repeat (5) @(posedge CLK);
    #1;
    MCycleOp = DIV_U;
    Operand1 = 32'd7;
    Operand2 = 32'd7;
    Start    = 1'b1;
    chk("ign_hold_mid", Result1, last_r1);
    @(posedge CLK);
    #1 Start = 1'b0;
    wait_done("mul_3x3_ign");
    hi_seen = 0;
    repeat (3) begin
      @(posedge CLK);
      #1;
      if (Busy) hi_seen++;
    end
    chk("ign_no_second_op", 32'(hi_seen), 32'd0);
    last_r1 = 32'd9;
    @(negedge CLK);

    // Reset during a divide aborts it with no partial result.
    @(posedge CLK);
    #1;
    MCycleOp = DIV_U;
    Operand1 = 32'd100;
    Operand2 = 32'd7;
    Start    = 1'b1;
    @(posedge CLK);
    #1 Start = 1'b0;
    repeat (10) @(posedge CLK);
    #1 RESET = 1'b0;
    #1;
    chk("abort_busy", {31'b0, Busy}, 32'd0);
    chk("abort_r1", Result1, 32'd0);
    chk("abort_r2", Result2, 32'd0);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RESET   = 1'b1;
    last_r1 = '0;

    run_op("mulu_2x2_post", MUL_U, 32'd2, 32'd2, 32'd4, 32'd0);

    repeat (2) @(posedge CLK);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
